// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default sizes and port-slice helper for regfile_mp.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_NUM_RD = 2;
   localparam int unsigned DEF_NUM_WR = 2;

   // Clear engine states
   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_e;

   // Low bit of port p inside a flattened port vector of per-port width w
   function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequences a zero sweep over [CLEAR_LO, CLEAR_HI] after reset or on request.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned CLEAR_LO = 1,
   parameter int unsigned CLEAR_HI = (32'd1 << ADDR_W) - 32'd1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req_i,
   output logic              clear_busy_o,
   output logic              clear_done_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_ptr_o
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // State register; reset starts a sweep from CLEAR_LO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLR_SWEEP;
         ptr_q   <= ADDR_W'(CLEAR_LO);
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state: one entry cleared per sweep cycle, done pulses in the first idle cycle
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            busy_d = 1'b0;
            if (clear_req_i) begin
               state_d = CLR_SWEEP;
               ptr_d   = ADDR_W'(CLEAR_LO);
               busy_d  = 1'b1;
            end
         end
         CLR_SWEEP: begin
            busy_d = 1'b1;
            if (ptr_q == ADDR_W'(CLEAR_HI)) begin
               state_d = CLR_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = CLR_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign clear_busy_o = busy_q;
   assign clear_done_o = done_q;
   assign clr_we_o     = busy_q;
   assign clr_ptr_o    = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with zero entry, port priority and clear sweep.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter int unsigned NUM_WR   = DEF_NUM_WR,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned CLEAR_LO = 1,
   parameter int unsigned CLEAR_HI = (32'd1 << ADDR_W) - 32'd1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic                     clear_req_i,
   output logic                     clear_busy_o,
   output logic                     clear_done_o,
   output logic                     wr_conflict_o
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_a  [NUM_WR];
   logic [DATA_W-1:0] wr_d  [NUM_WR];
   logic [NUM_WR-1:0] wr_eff;
   logic [ADDR_W-1:0] rd_a  [NUM_RD];
   logic [DATA_W-1:0] rd_v  [NUM_RD];
   logic              clr_busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_ptr;
   logic              conflict_d, conflict_q;

   function automatic logic in_clr_range(input logic [ADDR_W-1:0] a);
      return (int'(a) >= int'(CLEAR_LO)) && (int'(a) <= int'(CLEAR_HI));
   endfunction

   function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   regfile_clear_fsm #(
      .ADDR_W   (ADDR_W),
      .CLEAR_LO (CLEAR_LO),
      .CLEAR_HI (CLEAR_HI)
   ) u_clear_fsm (
      .clk          (clk),
      .reset        (reset),
      .clear_req_i  (clear_req_i),
      .clear_busy_o (clr_busy),
      .clear_done_o (clear_done_o),
      .clr_we_o     (clr_we),
      .clr_ptr_o    (clr_ptr)
   );

   assign clear_busy_o = clr_busy;

   // Unpack write ports; drop zero-entry writes and in-range writes while sweeping
   always_comb begin
      for (int p = 0; p < NUM_WR; p++) begin
         wr_a[p]   = wr_addr_i[port_lo(p, ADDR_W) +: ADDR_W];
         wr_d[p]   = wr_data_i[port_lo(p, DATA_W) +: DATA_W];
         wr_eff[p] = wr_en_i[p] && !is_zero_entry(wr_a[p])
                     && !(clr_busy && in_clr_range(wr_a[p]));
      end
   end

   // Any two surviving writes aimed at the same entry
   always_comb begin
      conflict_d = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (wr_eff[p] && wr_eff[q] && (wr_a[p] == wr_a[q])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Storage array: later ports override earlier ones; sweep writes never collide with kept writes
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_eff[p]) begin
            mem_q[wr_a[p]] <= wr_d[p];
         end
      end
      if (clr_we) begin
         mem_q[clr_ptr] <= '0;
      end
   end

   // Conflict flag, one cycle per conflicting write cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign wr_conflict_o = conflict_q;

   // Combinational read path: array, optional forwarding, then zero forcing
   always_comb begin
      rd_data_o = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         rd_a[r] = rd_addr_i[port_lo(r, ADDR_W) +: ADDR_W];
         rd_v[r] = mem_q[rd_a[r]];
`ifdef REGFILE_BYPASS_EN
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_eff[w] && (wr_a[w] == rd_a[r])) begin
               rd_v[r] = wr_d[w];
            end
         end
`else
`endif
         if (is_zero_entry(rd_a[r]) || (clr_busy && in_clr_range(rd_a[r]))) begin
            rd_v[r] = '0;
         end
         rd_data_o[port_lo(r, DATA_W) +: DATA_W] = rd_v[r];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against a behavioural model.
module tb_regfile_mp;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;
   localparam int LO    = 1;
   localparam int HI    = 31;
   localparam int SWEEP = HI - LO + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NW-1:0]    wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic             clear_req;
   logic             clear_busy;
   logic             clear_done;
   logic             wr_conflict;

   regfile_mp dut (
      .clk           (clk),
      .reset         (reset),
      .rd_addr_i     (rd_addr),
      .rd_data_o     (rd_data),
      .wr_en_i       (wr_en),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .clear_req_i   (clear_req),
      .clear_busy_o  (clear_busy),
      .clear_done_o  (clear_done),
      .wr_conflict_o (wr_conflict)
   );

   always #5 clk = ~clk;

   // Behavioural model: contents, sweep countdown, flags
   logic [31:0] mdl [DEPTH];
   bit          m_busy;
   int          m_left;
   bit          m_done;
   bit          m_conf;
   int          total = 0;
   int          bad = 0;
   int          done_pulses = 0;

   function automatic int wa(input int p);
      return int'(wr_addr[p*AW +: AW]);
   endfunction

   function automatic logic [31:0] wd(input int p);
      return wr_data[p*DW +: DW];
   endfunction

   function automatic bit dropped(input int a);
      return (a == 0) || (m_busy && a >= LO && a <= HI);
   endfunction

   function automatic logic [31:0] exp_read(input int a);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      if (m_busy && a >= LO && a <= HI) return 32'h0;
      v = mdl[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NW; p++)
         if (wr_en[p] && !dropped(wa(p)) && wa(p) == a) v = wd(p);
`endif
      return v;
   endfunction

   task automatic model_reset();
      m_busy = 1'b1;
      m_left = SWEEP;
      m_done = 1'b0;
      m_conf = 1'b0;
      for (int a = LO; a <= HI; a++) mdl[a] = 32'h0;
   endtask

   // Advance the model across one clock edge using the inputs held before it
   task automatic model_edge();
      bit c;
      c = 1'b0;
      if (reset) begin
         model_reset();
         return;
      end
      for (int p = 0; p < NW; p++)
         for (int q = p + 1; q < NW; q++)
            if (wr_en[p] && wr_en[q] && !dropped(wa(p)) && !dropped(wa(q)) && wa(p) == wa(q))
               c = 1'b1;
      for (int p = 0; p < NW; p++)
         if (wr_en[p] && !dropped(wa(p))) mdl[wa(p)] = wd(p);
      m_conf = c;
      if (m_busy) begin
         m_left = m_left - 1;
         m_done = (m_left == 0);
         if (m_done) m_busy = 1'b0;
      end else begin
         m_done = 1'b0;
         if (clear_req) begin
            m_busy = 1'b1;
            m_left = SWEEP;
            for (int a = LO; a <= HI; a++) mdl[a] = 32'h0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      #1;
      check("busy", 32'(clear_busy), 32'(m_busy));
      check("done", 32'(clear_done), 32'(m_done));
      check("conflict", 32'(wr_conflict), 32'(m_conf));
      check("rd0", rd_data[0 +: DW], exp_read(int'(rd_addr[0 +: AW])));
      check("rd1", rd_data[DW +: DW], exp_read(int'(rd_addr[AW +: AW])));
      if (clear_done === 1'b1) done_pulses++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic set_wr(input int p, input bit en, input int a, input logic [31:0] d);
      wr_en[p]          = en;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic idle_wr();
      for (int p = 0; p < NW; p++) set_wr(p, 1'b0, 0, 32'h0);
   endtask

   initial begin
      int busy_cycles;
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; clear_req = 1'b0;
      for (int a = 0; a < DEPTH; a++) mdl[a] = 32'h0;

      // Reset state
      #2 reset = 1'b1;
      model_reset();
      set_rd(0, 3); set_rd(1, 17);
      check_all();
      check("rst_busy", 32'(clear_busy), 32'd1);
      tick(); check_all();
      tick(); check_all();
      reset = 1'b0;
      check_all();

      // Initial sweep: busy for SWEEP cycles, reads zero, one done pulse
      done_pulses = 0;
      busy_cycles = (clear_busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < SWEEP + 2; i++) begin
         tick();
         set_rd(0, int'($urandom_range(1, 31)));
         set_rd(1, int'($urandom_range(1, 31)));
         check_all();
         if (clear_busy === 1'b1) busy_cycles++;
      end
      check("init_busy_len", 32'(busy_cycles), 32'(SWEEP));
      check("init_done_pulses", 32'(done_pulses), 32'd1);

      // Single write, read back on both ports
      set_wr(0, 1'b1, 5, 32'hDEADBEEF);
      set_rd(0, 5); set_rd(1, 5);
      check_all();
`ifdef REGFILE_BYPASS_EN
      check("addr5_bypass", rd_data[0 +: DW], 32'hDEADBEEF);
`endif
      tick(); idle_wr(); check_all();
      check("addr5_p0", rd_data[0 +: DW], 32'hDEADBEEF);
      check("addr5_p1", rd_data[DW +: DW], 32'hDEADBEEF);

      // Same-address write: port 1 wins, conflict for one cycle
      set_wr(0, 1'b1, 7, 32'h1); set_wr(1, 1'b1, 7, 32'h2);
      set_rd(0, 7); set_rd(1, 7);
      check_all();
      tick(); idle_wr(); check_all();
      check("addr7_win", rd_data[0 +: DW], 32'h2);
      check("conf7_set", 32'(wr_conflict), 32'd1);
      tick(); check_all();
      check("conf7_once", 32'(wr_conflict), 32'd0);

      // Zero entry ignores writes and does not raise conflict
      set_wr(0, 1'b1, 0, 32'hFFFFFFFF); set_wr(1, 1'b1, 0, 32'hFFFFFFFF);
      set_rd(0, 0); set_rd(1, 0);
      check_all();
      check("zero_same", rd_data[0 +: DW], 32'h0);
      tick(); idle_wr(); check_all();
      check("zero_rd", rd_data[DW +: DW], 32'h0);
      check("zero_conf", 32'(wr_conflict), 32'd0);

      // Requested sweep clears addr 3 and drops writes into the range
      set_wr(0, 1'b1, 3, 32'h55); set_rd(0, 3); set_rd(1, 3);
      tick(); idle_wr(); clear_req = 1'b1;
      check_all();
      check("addr3_pre", rd_data[0 +: DW], 32'h55);
      tick(); clear_req = 1'b0;
      check_all();
      check("addr3_clr", rd_data[0 +: DW], 32'h0);
      check("req_busy", 32'(clear_busy), 32'd1);
      set_wr(0, 1'b1, 3, 32'h77);
      tick(); idle_wr(); check_all();
      done_pulses = 0;
      for (int i = 0; i < 40 && m_busy; i++) begin
         tick(); check_all();
      end
      tick(); check_all();
      check("req_done_pulses", 32'(done_pulses), 32'd1);
      check("addr3_after", rd_data[0 +: DW], 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         tick();
         for (int p = 0; p < NW; p++) begin
            set_wr(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            if (m_busy && p == 1) wr_en[p] = 1'b0;
         end
         set_rd(0, int'($urandom_range(0, 7)));
         set_rd(1, int'($urandom_range(0, 31)));
         clear_req = ($urandom_range(0, 49) == 0);
         check_all();
      end
      idle_wr(); clear_req = 1'b0;
      for (int i = 0; i < 40 && (m_busy || m_done); i++) tick();
      check_all();

      // Reset in the middle of a sweep restarts it from CLEAR_LO
      clear_req = 1'b1;
      tick(); clear_req = 1'b0; check_all();
      for (int i = 0; i < 14; i++) begin
         tick(); check_all();
      end
      reset = 1'b1;
      model_reset();
      check_all();
      tick(); check_all();
      reset = 1'b0;
      check_all();
      done_pulses = 0;
      busy_cycles = (clear_busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < SWEEP + 2; i++) begin
         tick();
         set_rd(0, int'($urandom_range(1, 31)));
         check_all();
         if (clear_busy === 1'b1) busy_cycles++;
      end
      check("rst_busy_len", 32'(busy_cycles), 32'(SWEEP));
      check("rst_done_pulses", 32'(done_pulses), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
